// File: rtl/wb_lsu_master_if.sv
// ============================================================================
// Module   : wb_lsu_master_if
// Purpose  : Wishbone pipelined-mode bus between the LSU initiator and responders.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_lsu_master_if;
   logic        o_wb_cycle;
   logic        o_wb_stb;
   logic        o_wb_we;
   logic [3:0]  o_wb_sel;
   logic [29:0] o_wb_addr;
   logic [31:0] o_wb_mosi_data;
   logic        i_wb_ack;
   logic        i_wb_stall;
   logic [31:0] i_wb_miso_data;

   modport master (
      output o_wb_cycle, o_wb_stb, o_wb_we, o_wb_sel, o_wb_addr, o_wb_mosi_data,
      input  i_wb_ack, i_wb_stall, i_wb_miso_data
   );

   modport slave (
      input  o_wb_cycle, o_wb_stb, o_wb_we, o_wb_sel, o_wb_addr, o_wb_mosi_data,
      output i_wb_ack, i_wb_stall, i_wb_miso_data
   );
endinterface

`default_nettype wire

// File: rtl/wb_lsu_master.sv
// ============================================================================
// Module   : wb_lsu_master
// Purpose  : Single-beat Wishbone pipelined load/store initiator for the memory
//            stage. Optional bus timeout abort enabled by defining WB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_lsu_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_req_valid,
   output logic                   o_req_ready,
   input  logic                   i_req_we,
   input  logic [31:0]            i_req_addr,
   input  logic [1:0]             i_req_size,
   input  logic                   i_req_unsigned,
   input  logic [31:0]            i_req_wdata,
   output logic                   o_rsp_valid,
   output logic [31:0]            o_rsp_rdata,
   output logic                   o_rsp_err,
   wb_lsu_master_if.master        wb
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t      state_q;
   logic        ready_q;
   logic        rsp_valid_q;
   logic        rsp_err_q;
   logic [31:0] rsp_rdata_q;
   logic        cyc_q;
   logic        stb_q;
   logic        we_q;
   logic [3:0]  sel_q;
   logic [29:0] addr_q;
   logic [31:0] mosi_q;
   logic [1:0]  off_q;
   logic [1:0]  size_q;
   logic        uns_q;

   logic        illegal_d;
   logic [3:0]  sel_d;
   logic [31:0] mosi_d;
   logic [31:0] lane_d;
   logic [31:0] load_d;
   logic        done_d;
   logic        timeout_d;

   always_comb begin
      illegal_d = 1'b0;
      sel_d     = 4'b1111;
      mosi_d    = i_req_wdata;
      case (i_req_size)
         2'b00: begin
            sel_d  = 4'b0001 << i_req_addr[1:0];
            mosi_d = {4{i_req_wdata[7:0]}};
         end
         2'b01: begin
            sel_d     = 4'b0011 << i_req_addr[1:0];
            mosi_d    = {2{i_req_wdata[15:0]}};
            illegal_d = i_req_addr[0];
         end
         2'b10:   illegal_d = (i_req_addr[1:0] != 2'b00);
         default: illegal_d = 1'b1;
      endcase

      // Bring the addressed lane down to bit 0, then extend to 32 bits.
      lane_d = wb.i_wb_miso_data >> {off_q, 3'b000};
      case (size_q)
         2'b00:   load_d = {{24{~uns_q & lane_d[7]}},  lane_d[7:0]};
         2'b01:   load_d = {{16{~uns_q & lane_d[15]}}, lane_d[15:0]};
         default: load_d = lane_d;
      endcase

      done_d = wb.i_wb_ack & (((state_q == REQ) & ~wb.i_wb_stall) | (state_q == WAIT));
   end

`ifdef WB_TIMEOUT_EN
   localparam int unsigned c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [c_CNT_W-1:0] cnt_q;
   logic [c_CNT_W-1:0] cnt_d;

   // Compare the post-increment count so the bus is held exactly TIMEOUT_CYCLES.
   assign cnt_d     = cnt_q + c_CNT_W'(1);
   assign timeout_d = (cnt_d == c_CNT_W'(TIMEOUT_CYCLES));
`else
   logic w_unused_timeout;
   assign w_unused_timeout = |TIMEOUT_CYCLES;
   assign timeout_d        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'd0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= 4'd0;
         addr_q      <= 30'd0;
         mosi_q      <= 32'd0;
         off_q       <= 2'd0;
         size_q      <= 2'd0;
         uns_q       <= 1'b0;
`ifdef WB_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_req_valid) begin
                  ready_q <= 1'b0;
                  off_q   <= i_req_addr[1:0];
                  size_q  <= i_req_size;
                  uns_q   <= i_req_unsigned;
                  if (illegal_d) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= 32'd0;
                  end else begin
                     state_q <= REQ;
                     cyc_q   <= 1'b1;
                     stb_q   <= 1'b1;
                     we_q    <= i_req_we;
                     sel_q   <= sel_d;
                     addr_q  <= i_req_addr[31:2];
                     mosi_q  <= mosi_d;
`ifdef WB_TIMEOUT_EN
                     cnt_q   <= '0;
`endif
                  end
               end
            end
            REQ, WAIT: begin
`ifdef WB_TIMEOUT_EN
               cnt_q <= cnt_d;
`endif
               if (done_d) begin
                  state_q     <= RESP;
                  cyc_q       <= 1'b0;
                  stb_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= we_q ? 32'd0 : load_d;
               end else if (timeout_d) begin
                  state_q     <= RESP;
                  cyc_q       <= 1'b0;
                  stb_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= 32'd0;
               end else if ((state_q == REQ) && !wb.i_wb_stall) begin
                  state_q <= WAIT;
                  stb_q   <= 1'b0;
               end
            end
            RESP: begin
               state_q   <= IDLE;
               ready_q   <= 1'b1;
               rsp_err_q <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_req_ready       = ready_q;
   assign o_rsp_valid       = rsp_valid_q;
   assign o_rsp_err         = rsp_err_q;
   assign o_rsp_rdata       = rsp_rdata_q;
   assign wb.o_wb_cycle     = cyc_q;
   assign wb.o_wb_stb       = stb_q;
   assign wb.o_wb_we        = we_q;
   assign wb.o_wb_sel       = sel_q;
   assign wb.o_wb_addr      = addr_q;
   assign wb.o_wb_mosi_data = mosi_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_lsu_master.sv
// ============================================================================
// Module   : tb_wb_lsu_master
// Purpose  : Randomized self-checking bench for wb_lsu_master with a reference
//            model of lane selection, alignment and load extension.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_lsu_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req_valid;
   logic        o_req_ready;
   logic        i_req_we;
   logic [31:0] i_req_addr;
   logic [1:0]  i_req_size;
   logic        i_req_unsigned;
   logic [31:0] i_req_wdata;
   logic        o_rsp_valid;
   logic [31:0] o_rsp_rdata;
   logic        o_rsp_err;

   int n_checks = 0;
   int n_errors = 0;

   wb_lsu_master_if wb_bus ();

   wb_lsu_master #(.TIMEOUT_CYCLES(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .i_req_valid    (i_req_valid),
      .o_req_ready    (o_req_ready),
      .i_req_we       (i_req_we),
      .i_req_addr     (i_req_addr),
      .i_req_size     (i_req_size),
      .i_req_unsigned (i_req_unsigned),
      .i_req_wdata    (i_req_wdata),
      .o_rsp_valid    (o_rsp_valid),
      .o_rsp_rdata    (o_rsp_rdata),
      .o_rsp_err      (o_rsp_err),
      .wb             (wb_bus)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: natural alignment, lane masks and extension by arithmetic.
   function automatic logic ref_illegal(input logic [1:0] size, input logic [31:0] addr);
      int nb;
      if (size == 2'd3) return 1'b1;
      nb = 1 << size;
      return (addr % nb) != 0;
   endfunction

   function automatic logic [3:0] ref_sel(input logic [1:0] size, input logic [31:0] addr);
      logic [31:0] t;
      int nb;
      nb = 1 << size;
      t  = ((32'd1 << nb) - 32'd1) << (addr % 4);
      return t[3:0];
   endfunction

   function automatic logic [31:0] ref_mosi(input logic [1:0] size, input logic [31:0] wd);
      if (size == 2'd0) return {24'd0, wd[7:0]} * 32'h0101_0101;
      if (size == 2'd1) return {16'd0, wd[15:0]} * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] size, input logic [31:0] addr,
                                            input logic uns, input logic [31:0] miso);
      logic [63:0] m;
      logic [63:0] v;
      int nb;
      nb = 1 << size;
      m  = 64'd1 << (8 * nb);
      v  = ({32'd0, miso} >> (8 * (addr % 4))) % m;
      if (!uns && (v >= m / 2)) v = v - m;
      return v[31:0];
   endfunction

   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata, input int stalls,
                          input int ack_dly, input logic [31:0] resp,
                          output logic [31:0] rdata_seen);
      logic [31:0] exp_load;
      @(negedge clk);
      check_value("ready_idle", {31'd0, o_req_ready}, 32'd1);
      i_req_valid    = 1'b1;
      i_req_we       = we;
      i_req_addr     = addr;
      i_req_size     = size;
      i_req_unsigned = uns;
      i_req_wdata    = wdata;
      @(negedge clk);
      i_req_valid    = 1'b0;
      i_req_addr     = $urandom;
      i_req_wdata    = $urandom;
      rdata_seen     = o_rsp_rdata;
      if (ref_illegal(size, addr)) begin
         check_value("ill_valid", {31'd0, o_rsp_valid}, 32'd1);
         check_value("ill_err", {31'd0, o_rsp_err}, 32'd1);
         check_value("ill_rdata", o_rsp_rdata, 32'd0);
         check_value("ill_cyc", {31'd0, wb_bus.o_wb_cycle}, 32'd0);
         wb_bus.i_wb_ack = 1'($urandom);
         @(negedge clk);
         check_value("ill_pulse", {31'd0, o_rsp_valid}, 32'd0);
         check_value("ill_cyc2", {31'd0, wb_bus.o_wb_cycle}, 32'd0);
         check_value("ill_ready", {31'd0, o_req_ready}, 32'd1);
         wb_bus.i_wb_ack = 1'b0;
         return;
      end
      exp_load = we ? 32'd0 : ref_load(size, addr, uns, resp);
      for (int k = 0; k <= stalls; k++) begin
         check_value("req_cyc", {31'd0, wb_bus.o_wb_cycle}, 32'd1);
         check_value("req_stb", {31'd0, wb_bus.o_wb_stb}, 32'd1);
         check_value("req_addr", {2'd0, wb_bus.o_wb_addr}, {2'd0, addr[31:2]});
         check_value("req_sel", {28'd0, wb_bus.o_wb_sel}, {28'd0, ref_sel(size, addr)});
         check_value("req_we", {31'd0, wb_bus.o_wb_we}, {31'd0, we});
         if (we) check_value("req_mosi", wb_bus.o_wb_mosi_data, ref_mosi(size, wdata));
         check_value("req_novalid", {31'd0, o_rsp_valid}, 32'd0);
         check_value("req_notready", {31'd0, o_req_ready}, 32'd0);
         wb_bus.i_wb_stall = (k < stalls);
         if (k < stalls) begin
            wb_bus.i_wb_ack       = 1'($urandom);
            wb_bus.i_wb_miso_data = $urandom;
         end else begin
            wb_bus.i_wb_ack       = (ack_dly == 0);
            wb_bus.i_wb_miso_data = (ack_dly == 0) ? resp : $urandom;
         end
         @(negedge clk);
      end
      for (int d = 1; d <= ack_dly; d++) begin
         check_value("wait_cyc", {31'd0, wb_bus.o_wb_cycle}, 32'd1);
         check_value("wait_stb", {31'd0, wb_bus.o_wb_stb}, 32'd0);
         check_value("wait_novalid", {31'd0, o_rsp_valid}, 32'd0);
         wb_bus.i_wb_stall     = 1'($urandom);
         wb_bus.i_wb_ack       = (d == ack_dly);
         wb_bus.i_wb_miso_data = (d == ack_dly) ? resp : $urandom;
         @(negedge clk);
      end
      wb_bus.i_wb_stall = 1'b0;
      wb_bus.i_wb_ack   = 1'($urandom);
      check_value("rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
      check_value("rsp_err", {31'd0, o_rsp_err}, 32'd0);
      check_value("rsp_rdata", o_rsp_rdata, exp_load);
      check_value("rsp_cyc", {31'd0, wb_bus.o_wb_cycle}, 32'd0);
      check_value("rsp_stb", {31'd0, wb_bus.o_wb_stb}, 32'd0);
      rdata_seen = o_rsp_rdata;
      @(negedge clk);
      check_value("rsp_pulse", {31'd0, o_rsp_valid}, 32'd0);
      check_value("rsp_ready", {31'd0, o_req_ready}, 32'd1);
      wb_bus.i_wb_ack = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] seen;
      int          n;
      reset                 = 1'b1;
      i_req_valid           = 1'b0;
      i_req_we              = 1'b0;
      i_req_addr            = 32'd0;
      i_req_size            = 2'd0;
      i_req_unsigned        = 1'b0;
      i_req_wdata           = 32'd0;
      wb_bus.i_wb_ack       = 1'b0;
      wb_bus.i_wb_stall     = 1'b0;
      wb_bus.i_wb_miso_data = 32'd0;
      repeat (3) @(negedge clk);
      check_value("rst_ready", {31'd0, o_req_ready}, 32'd1);
      check_value("rst_valid", {31'd0, o_rsp_valid}, 32'd0);
      check_value("rst_err", {31'd0, o_rsp_err}, 32'd0);
      check_value("rst_rdata", o_rsp_rdata, 32'd0);
      check_value("rst_cyc", {31'd0, wb_bus.o_wb_cycle}, 32'd0);
      check_value("rst_stb", {31'd0, wb_bus.o_wb_stb}, 32'd0);
      check_value("rst_sel", {28'd0, wb_bus.o_wb_sel}, 32'd0);
      check_value("rst_addr", {2'd0, wb_bus.o_wb_addr}, 32'd0);
      reset = 1'b0;

      run_txn(1'b0, 32'h0000_0100, 2'd2, 1'b0, 32'd0, 0, 1, 32'hDEAD_BEEF, seen);
      check_value("tp_word", seen, 32'hDEAD_BEEF);
      run_txn(1'b0, 32'h0000_0103, 2'd0, 1'b0, 32'd0, 0, 1, 32'h80AA_BBCC, seen);
      check_value("tp_sbyte", seen, 32'hFFFF_FF80);
      run_txn(1'b0, 32'h0000_0103, 2'd0, 1'b1, 32'd0, 0, 1, 32'h80AA_BBCC, seen);
      check_value("tp_ubyte", seen, 32'h0000_0080);
      run_txn(1'b1, 32'h0000_0002, 2'd1, 1'b0, 32'h0000_1234, 3, 1, 32'hFFFF_FFFF, seen);
      check_value("tp_store", seen, 32'd0);
      run_txn(1'b0, 32'h0000_0102, 2'd2, 1'b0, 32'd0, 0, 1, 32'd0, seen);
      check_value("tp_misalign", seen, 32'd0);

      // Reset while waiting for ack: bus drops and no response ever appears.
      @(negedge clk);
      i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h200; i_req_size = 2'd2;
      @(negedge clk);
      i_req_valid = 1'b0;
      @(negedge clk);
      check_value("rw_wait_cyc", {31'd0, wb_bus.o_wb_cycle}, 32'd1);
      check_value("rw_wait_stb", {31'd0, wb_bus.o_wb_stb}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_value("rw_cyc", {31'd0, wb_bus.o_wb_cycle}, 32'd0);
      check_value("rw_ready", {31'd0, o_req_ready}, 32'd1);
      wb_bus.i_wb_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         check_value("rw_novalid", {31'd0, o_rsp_valid}, 32'd0);
         @(negedge clk);
         wb_bus.i_wb_ack = 1'b0;
      end

      for (int t = 0; t < 80; t++) begin
         run_txn(1'($urandom), $urandom, 2'($urandom_range(0, 3)), 1'($urandom), $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom, seen);
      end

`ifdef WB_TIMEOUT_EN
      @(negedge clk);
      i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h300; i_req_size = 2'd2;
      @(negedge clk);
      i_req_valid = 1'b0;
      wb_bus.i_wb_ack = 1'b0;
      n = 0;
      while (wb_bus.o_wb_cycle && n < 50) begin
         n++;
         @(negedge clk);
      end
      check_value("to_cycles", 32'(n), 32'd8);
      check_value("to_valid", {31'd0, o_rsp_valid}, 32'd1);
      check_value("to_err", {31'd0, o_rsp_err}, 32'd1);
      check_value("to_rdata", o_rsp_rdata, 32'd0);
      wb_bus.i_wb_ack = 1'b1;
      @(negedge clk);
      wb_bus.i_wb_ack = 1'b0;
      check_value("to_late_ack", {31'd0, o_rsp_valid}, 32'd0);
      @(negedge clk);
      check_value("to_late_ack2", {31'd0, o_rsp_valid}, 32'd0);
      check_value("to_ready", {31'd0, o_req_ready}, 32'd1);
`else
      n = 0;
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
